// File: rtl/n64_cfg_mailbox.sv
// N64-side configuration mailbox: command FIFO, argument/result words, per-command
// timeout, overflow detection and a maskable completion interrupt.
module n64_cfg_mailbox #(
  parameter int unsigned DATA_WORDS     = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] VERSION        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     n64_reset,
  input  logic [16:0]              reg_address,
  input  logic                     reg_write,
  input  logic [15:0]              reg_wdata,
  output logic [15:0]              reg_rdata,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_data,
  output logic [32*DATA_WORDS-1:0] args,
  input  logic                     done,
  input  logic                     done_error,
  input  logic [DATA_WORDS-1:0]    result_we,
  input  logic [32*DATA_WORDS-1:0] result,
  output logic                     irq
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [31:0] TimeoutLast = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q, fifo_count;
  logic [7:0]                   fifo_mem [FIFO_DEPTH];
  logic                         error_q, error_d, timeout_q, timeout_d;
  logic                         overflow_q, overflow_d, irq_q, irq_d, mask_q, mask_d;
  logic [DATA_WORDS-1:0][31:0]  data_q, data_d;

  logic       rst, win, wr_en, cmd_write, push, pop, empty, full, busy;
  logic       finish, fin_err, fin_to;
  logic [4:0] idx;
  logic       unused_addr_lsb;

  assign rst             = reset | n64_reset;
  assign win             = reg_address[16] && (reg_address[15:6] == '0);
  assign idx             = reg_address[5:1];
  assign wr_en           = win && reg_write;
  assign unused_addr_lsb = reg_address[0];

  // Extra pointer MSB distinguishes full from empty after wrap-around.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign busy       = !empty || (state_q == StExec);

  assign cmd_write = wr_en && (idx == 5'd1);
  assign push      = cmd_write && !full;
  assign cmd_valid = !empty && (state_q == StIdle);
  assign pop       = cmd_valid && cmd_ready;
  assign cmd_data  = fifo_mem[rd_ptr_q[AddrW-1:0]];
  assign args      = data_q;
  assign irq       = irq_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    fin_err = 1'b0;
    fin_to  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        // done takes priority over a coincident timeout terminal count.
        if (done) begin
          state_d = StIdle;
          finish  = 1'b1;
          fin_err = done_error;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast)) begin
          state_d = StIdle;
          finish  = 1'b1;
          fin_err = 1'b1;
          fin_to  = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    error_d    = error_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    irq_d      = irq_q;
    mask_d     = mask_q;
    if (push) begin
      error_d   = 1'b0;
      timeout_d = 1'b0;
    end
    if (finish) begin
      error_d = fin_err;
      if (fin_to) timeout_d = 1'b1;
    end
    if (cmd_write && !busy) overflow_d = 1'b0;
    if (cmd_write && full)  overflow_d = 1'b1;
    if (wr_en && (idx == 5'd2)) mask_d = reg_wdata[0];
    if (wr_en && (idx == 5'd4)) irq_d = 1'b0;
    if (finish && mask_q)       irq_d = 1'b1;
  end

  always_comb begin
    data_d = data_q;
    for (int unsigned k = 0; k < DATA_WORDS; k++) begin
      if (wr_en && (32'(idx) == 8 + 2 * k)) data_d[k][31:16] = reg_wdata;
      if (wr_en && (32'(idx) == 9 + 2 * k)) data_d[k][15:0]  = reg_wdata;
      if (result_we[k]) data_d[k] = result[32*k +: 32];
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (win) begin
      case (idx)
        5'd0: reg_rdata = {busy, error_q, timeout_q, overflow_q, full, 5'(fifo_count), 6'b0};
        5'd2: reg_rdata = {15'b0, mask_q};
        5'd3: reg_rdata = VERSION[31:16];
        5'd4: reg_rdata = VERSION[15:0];
        default: begin
          for (int unsigned k = 0; k < DATA_WORDS; k++) begin
            if (32'(idx) == 8 + 2 * k) reg_rdata = data_q[k][31:16];
            if (32'(idx) == 9 + 2 * k) reg_rdata = data_q[k][15:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      mask_q     <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_q[AddrW-1:0]] <= reg_wdata[7:0];
  end

endmodule

// File: tb/tb_n64_cfg_mailbox.sv
// Self-checking bench for n64_cfg_mailbox: register vector table plus command
// scoreboard and hand-written sequences for FIFO, timeout, mask and reset corners.
module tb_n64_cfg_mailbox;

  localparam int unsigned DW = 2;
  localparam logic [31:0] Ver = 32'hA5C3_0F1E;

  logic            clk = 1'b0;
  logic            reset = 1'b1, n64_reset = 1'b0;
  logic [16:0]     reg_address = '0;
  logic            reg_write = 1'b0;
  logic [15:0]     reg_wdata = '0;
  logic [15:0]     reg_rdata;
  logic            cmd_valid, cmd_ready = 1'b0;
  logic [7:0]      cmd_data;
  logic [32*DW-1:0] args;
  logic            done = 1'b0, done_error = 1'b0;
  logic [DW-1:0]   result_we = '0;
  logic [32*DW-1:0] result = '0;
  logic            irq;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  logic [7:0] sb_exp;

  n64_cfg_mailbox #(
    .DATA_WORDS(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .VERSION(Ver)
  ) dut (
    .clk(clk), .reset(reset), .n64_reset(n64_reset),
    .reg_address(reg_address), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .args(args), .done(done), .done_error(done_error),
    .result_we(result_we), .result(result), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  // Scoreboard: every accepted command byte must match the next queued byte.
  always @(negedge clk) begin
    if (!reset && !n64_reset && cmd_valid && cmd_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected act=%h req=none", cmd_data);
      end else begin
        sb_exp = sb.pop_front();
        if (cmd_data !== sb_exp) begin
          n_err++;
          $display("FAIL pop_order act=%h req=%h", cmd_data, sb_exp);
        end
      end
    end
  end

  function automatic logic [16:0] ra(input int idx);
    logic [4:0] i5;
    i5 = idx[4:0];
    return {1'b1, 10'b0, i5, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [16:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    reg_address = a; reg_wdata = d; reg_write = 1'b1;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [15:0] d);
    wr_a(ra(idx), d);
  endtask

  task automatic rd_a(input logic [16:0] a, output logic [15:0] v);
    @(posedge clk); #1;
    reg_address = a; reg_write = 1'b0;
    @(negedge clk);
    v = reg_rdata;
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    rd_a(ra(idx), v);
    check(name, 32'(v), 32'(exp));
  endtask

  task automatic wait_pop();
    int c = 0;
    @(negedge clk);
    while (!cmd_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("cmd_valid_wait", 32'(cmd_valid), 32'd1);
    if (cmd_valid) begin
      @(posedge clk); #1 cmd_ready = 1'b1;
      @(posedge clk); #1 cmd_ready = 1'b0;
    end
  endtask

  task automatic done_pulse(input logic err);
    @(posedge clk); #1 done = 1'b1; done_error = err;
    @(posedge clk); #1 done = 1'b0; done_error = 1'b0;
  endtask

  typedef struct {
    logic [16:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic [15:0] v;

    vt[0]  = '{ra(8),     1'b1, 16'h1234, 16'h1234};
    vt[1]  = '{ra(9),     1'b1, 16'h5678, 16'h5678};
    vt[2]  = '{ra(10),    1'b1, 16'hBEEF, 16'hBEEF};
    vt[3]  = '{ra(11),    1'b1, 16'hCAFE, 16'hCAFE};
    vt[4]  = '{ra(3),     1'b0, 16'h0000, 16'hA5C3};
    vt[5]  = '{ra(4),     1'b0, 16'h0000, 16'h0F1E};
    vt[6]  = '{ra(3),     1'b1, 16'h0000, 16'hA5C3};
    vt[7]  = '{ra(5),     1'b1, 16'hFFFF, 16'h0000};
    vt[8]  = '{ra(12),    1'b1, 16'h7777, 16'h0000};
    vt[9]  = '{17'h00012, 1'b1, 16'hFFFF, 16'h0000};
    vt[10] = '{ra(9),     1'b0, 16'h0000, 16'h5678};
    vt[11] = '{17'h10052, 1'b1, 16'hAAAA, 16'h0000};
    vt[12] = '{ra(9),     1'b0, 16'h0000, 16'h5678};
    vt[13] = '{ra(2),     1'b1, 16'h0000, 16'h0000};
    vt[14] = '{ra(2),     1'b1, 16'h0001, 16'h0001};
    vt[15] = '{ra(0),     1'b0, 16'h0000, 16'h0000};
    vt[16] = '{ra(1),     1'b0, 16'h0000, 16'h0000};
    vt[17] = '{ra(31),    1'b1, 16'h1234, 16'h0000};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_args", args[31:0] | args[63:32], 32'd0);
    chk_reg("rst_status", 0, 16'h0000);
    chk_reg("rst_mask", 2, 16'h0001);

    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) wr_a(vt[i].addr, vt[i].wdata);
      rd_a(vt[i].addr, v);
      check($sformatf("vec%0d", i), 32'(v), 32'(vt[i].exp));
    end
    check("args_w0", args[31:0], 32'h1234_5678);
    check("args_w1", args[63:32], 32'hBEEF_CAFE);

    // Basic command: 1-cycle push-to-valid latency, then completion and irq clear.
    @(posedge clk); #1;
    reg_address = ra(1); reg_wdata = 16'h0005; reg_write = 1'b1;
    sb.push_back(8'h05);
    @(negedge clk);
    check("valid_before_push", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1 reg_write = 1'b0;
    @(negedge clk);
    check("valid_after_push", 32'(cmd_valid), 32'd1);
    check("cmd_data_head", 32'(cmd_data), 32'h05);
    wait_pop();
    chk_reg("status_exec", 0, 16'h8000);
    done_pulse(1'b0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    chk_reg("status_done", 0, 16'h0000);
    wr(4, 16'h0000);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);

    // Overflow: fifth byte is dropped and the sticky flag set.
    for (int i = 0; i < 5; i++) begin
      wr(1, 16'(8'h10 + i));
      if (i < 4) sb.push_back(8'(8'h10 + i));
    end
    chk_reg("status_full_ovf", 0, 16'h9900);
    for (int i = 0; i < 4; i++) begin
      wait_pop();
      done_pulse(1'b0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("no_fifth_cmd", 32'(cmd_valid), 32'd0);
    chk_reg("ovf_sticky", 0, 16'h1000);
    wr(1, 16'h0020);
    sb.push_back(8'h20);
    chk_reg("ovf_cleared", 0, 16'h8040);
    wait_pop();
    done_pulse(1'b0);
    wr(4, 16'h0000);

    // Timeout after 16 EXEC cycles; a late done is ignored.
    wr(1, 16'h0030);
    sb.push_back(8'h30);
    wait_pop();
    reg_address = ra(0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("to_cycle15_busy", 32'(reg_rdata), 32'h8000);
    @(posedge clk);
    @(negedge clk);
    check("to_status", 32'(reg_rdata), 32'h6000);
    check("to_irq", 32'(irq), 32'd1);
    wr(4, 16'h0000);
    done_pulse(1'b0);
    @(negedge clk);
    check("late_done_irq", 32'(irq), 32'd0);
    chk_reg("late_done_status", 0, 16'h6000);

    // Masked completion with error; next COMMAND clears error.
    wr(2, 16'h0000);
    wr(1, 16'h0040);
    sb.push_back(8'h40);
    wait_pop();
    done_pulse(1'b1);
    @(negedge clk);
    check("masked_irq", 32'(irq), 32'd0);
    chk_reg("masked_err", 0, 16'h4000);
    wr(1, 16'h0041);
    sb.push_back(8'h41);
    chk_reg("err_cleared", 0, 16'h8040);
    wr(2, 16'h0001);
    wait_pop();
    done_pulse(1'b0);
    @(negedge clk);
    check("unmasked_irq", 32'(irq), 32'd1);

    // n64_reset mid-EXEC with two queued entries.
    wr(2, 16'h0000);
    wr(1, 16'h0050);
    sb.push_back(8'h50);
    wait_pop();
    wr(1, 16'h0051);
    wr(1, 16'h0052);
    chk_reg("pre_reset_status", 0, 16'h8080);
    @(posedge clk); #1 n64_reset = 1'b1;
    @(posedge clk); #1 n64_reset = 1'b0;
    @(negedge clk);
    check("nrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("nrst_irq", 32'(irq), 32'd0);
    check("nrst_args", args[31:0] | args[63:32], 32'd0);
    chk_reg("nrst_status", 0, 16'h0000);
    chk_reg("nrst_mask", 2, 16'h0001);
    done_pulse(1'b1);
    @(negedge clk);
    check("nrst_done_irq", 32'(irq), 32'd0);
    chk_reg("nrst_done_status", 0, 16'h0000);

    // result_we beats a same-cycle register write to the same word.
    wr(10, 16'h1111);
    @(posedge clk); #1;
    reg_address = ra(11); reg_wdata = 16'h9999; reg_write = 1'b1;
    result_we = 2'b10; result = {32'hDEAD_BEEF, 32'h1357_9BDF};
    @(posedge clk); #1;
    reg_write = 1'b0; result_we = '0;
    @(negedge clk);
    check("result_wins", args[63:32], 32'hDEAD_BEEF);
    check("result_other_word", args[31:0], 32'h0000_0000);
    @(posedge clk); #1 result_we = 2'b01;
    @(posedge clk); #1 result_we = '0;
    @(negedge clk);
    check("result_w0", args[31:0], 32'h1357_9BDF);
    check("result_w1_hold", args[63:32], 32'hDEAD_BEEF);
    chk_reg("data1_l_read", 11, 16'hBEEF);
    chk_reg("version_h", 3, 16'hA5C3);
    chk_reg("version_l", 4, 16'h0F1E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
